// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : LoongArch MEM stage - load alignment/extension, response
//             buffering while WB stalls, and discard of flushed responses.
// Revision  : 1.0
// ============================================================================
module mem_stage #(
  parameter int TLBNUM = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         final_ex,
  input  logic         back_ertn_flush,
  input  logic         ws_allowin,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [178:0] es_to_ms_bus,
  output logic         ms_to_ws_valid,
  output logic [178:0] ms_to_ws_bus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic [57:0]  ms_forward,
  output logic         ms_ertn_flush,
  output logic         ms_to_es_valid,
  output logic         ms_to_es_ex
);

  // TLB field carries the entry index plus four flag bits
  localparam int TLB_W = $clog2(TLBNUM) + 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DROP = 1'b1
  } drop_state_e;

  logic         ms_valid_q, ms_valid_d;
  logic [178:0] bus_q, bus_d;
  logic         buf_valid_q, buf_valid_d;
  logic [31:0]  rdata_buf_q, rdata_buf_d;
  drop_state_e  state_q, state_d;

  logic        flush, need_resp, drop, resp_seen, ms_ready_go, leave;
  logic        ex, ertn, res_from_mem;
  logic [1:0]  addr;
  logic [31:0] rd, load_data, final_result;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign ex           = bus_q[160];
  assign ertn         = bus_q[168];
  assign res_from_mem = bus_q[70];
  assign addr         = bus_q[79:78];

  assign flush       = final_ex | back_ertn_flush;
  assign need_resp   = ms_valid_q & (res_from_mem | bus_q[72] | bus_q[71] | bus_q[170]) & ~ex;
  assign drop        = (state_q == DROP);
  assign resp_seen   = buf_valid_q | (data_sram_data_ok & ~drop);
  assign ms_ready_go = ~need_resp | resp_seen;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign leave       = ms_to_ws_valid & ws_allowin;

  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    state_d     = state_q;

    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (es_to_ms_valid && ms_allowin) begin
      bus_d = es_to_ms_bus;
    end

    // Hold the beat only while WB refuses it; otherwise it is consumed directly
    if (flush || leave) begin
      buf_valid_d = 1'b0;
    end else if (data_sram_data_ok && !drop && need_resp && !ws_allowin) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end

    case (state_q)
      IDLE:    if (flush && need_resp && !resp_seen) state_d = DROP;
      DROP:    if (data_sram_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      buf_valid_q <= 1'b0;
      rdata_buf_q <= '0;
      state_q     <= IDLE;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      buf_valid_q <= buf_valid_d;
      rdata_buf_q <= rdata_buf_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    rd = buf_valid_q ? rdata_buf_q : data_sram_rdata;
    case (addr)
      2'd0:    rd_byte = rd[7:0];
      2'd1:    rd_byte = rd[15:8];
      2'd2:    rd_byte = rd[23:16];
      default: rd_byte = rd[31:24];
    endcase
    rd_half = addr[1] ? rd[31:16] : rd[15:0];

    if (bus_q[76])      load_data = {{24{rd_byte[7]}}, rd_byte};
    else if (bus_q[75]) load_data = {24'd0, rd_byte};
    else if (bus_q[74]) load_data = {{16{rd_half[15]}}, rd_half};
    else if (bus_q[73]) load_data = {16'd0, rd_half};
    else                load_data = rd;

    final_result = res_from_mem ? load_data : bus_q[63:32];
  end

  assign ms_to_ws_bus = {bus_q[178 -: TLB_W], bus_q[170:161], ex & ms_valid_q,
                         bus_q[159:71], 1'b0, bus_q[69:64], final_result, bus_q[31:0]};

  assign ms_forward = {ms_valid_q & res_from_mem & ~ms_ready_go,
                       bus_q[159], bus_q[158:145], bus_q[80],
                       ertn, ex, final_result, bus_q[68:64], bus_q[69], ms_valid_q};

  assign ms_ertn_flush  = ms_valid_q & ertn;
  assign ms_to_es_valid = ms_valid_q;
  assign ms_to_es_ex    = ms_valid_q & ex;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : randomized and directed checks of mem_stage against a
//                behavioural load/handshake model.
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;

  localparam int OP_LDW  = 0;
  localparam int OP_LDB  = 1;
  localparam int OP_LDBU = 2;
  localparam int OP_LDH  = 3;
  localparam int OP_LDHU = 4;
  localparam int OP_STB  = 5;
  localparam int OP_STH  = 6;
  localparam int OP_STW  = 7;
  localparam int OP_ALU  = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         final_ex, back_ertn_flush, ws_allowin, ms_allowin;
  logic         es_to_ms_valid, ms_to_ws_valid;
  logic [178:0] es_to_ms_bus, ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [57:0]  ms_forward;
  logic         ms_ertn_flush, ms_to_es_valid, ms_to_es_ex;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.TLBNUM(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .final_ex          (final_ex),
    .back_ertn_flush   (back_ertn_flush),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_forward        (ms_forward),
    .ms_ertn_flush     (ms_ertn_flush),
    .ms_to_es_valid    (ms_to_es_valid),
    .ms_to_es_ex       (ms_to_es_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [178:0] obs, input logic [178:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [178:0] mk(input int op, input logic [1:0] addr, input logic ex,
                                      input logic ertn, input logic [31:0] result);
    logic [178:0] b;
    b = '0;
    b[178:161] = 18'($urandom);
    b[159:128] = $urandom;
    b[127:96]  = $urandom;
    b[95:80]   = 16'($urandom);
    b[69:64]   = 6'($urandom);
    b[31:0]    = $urandom;
    b[170]     = (op == OP_STW);
    b[168]     = ertn;
    b[160]     = ex;
    b[79:78]   = addr;
    b[77]      = (op == OP_LDW);
    b[76]      = (op == OP_LDB);
    b[75]      = (op == OP_LDBU);
    b[74]      = (op == OP_LDH);
    b[73]      = (op == OP_LDHU);
    b[72]      = (op == OP_STB);
    b[71]      = (op == OP_STH);
    b[70]      = (op <= OP_LDHU);
    b[63:32]   = result;
    return b;
  endfunction

  // Reference load value from plain shift/mask arithmetic
  function automatic logic [31:0] ref_load(input int op, input logic [1:0] addr, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * addr)) & 32'hFF;
    h = (rd >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      OP_LDB:  return (b >= 32'd128) ? b - 32'd256 : b;
      OP_LDBU: return b;
      OP_LDH:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      OP_LDHU: return h;
      default: return rd;
    endcase
  endfunction

  // wsmode: 0 random, 1 always ready, 2 stalled until three cycles after data_ok
  task automatic run_instr(input int op, input logic [1:0] addr, input logic ex, input logic ertn,
                           input logic [31:0] result, input logic [31:0] rd, input int lat,
                           input int wsmode);
    logic [178:0] b, exp_bus;
    logic         need, given, done, rfm, ready;
    logic [31:0]  fin;
    int           cyc;
    b       = mk(op, addr, ex, ertn, result);
    rfm     = (op <= OP_LDHU);
    need    = (op != OP_ALU) && !ex;
    fin     = rfm ? ref_load(op, addr, rd) : result;
    exp_bus = b;
    exp_bus[63:32] = fin;
    exp_bus[70]    = 1'b0;

    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = b;
    data_sram_data_ok = 1'b0;
    ws_allowin        = 1'($urandom);
    #1;
    chk("allowin_empty", 179'(ms_allowin), 179'(1));
    @(posedge clk);
    #1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    given = 1'b0;
    done  = 1'b0;
    cyc   = 0;
    while (!done && cyc < 40) begin
      data_sram_data_ok = need && !given && (cyc == lat);
      data_sram_rdata   = data_sram_data_ok ? rd : $urandom;
      case (wsmode)
        0:       ws_allowin = 1'($urandom);
        1:       ws_allowin = 1'b1;
        default: ws_allowin = (cyc >= lat + 3);
      endcase
      if (cyc > 20) ws_allowin = 1'b1;
      #1;
      if (data_sram_data_ok) given = 1'b1;
      ready = !need || given;
      chk("ms_to_ws_valid", 179'(ms_to_ws_valid), 179'(ready));
      chk("ld_block", 179'(ms_forward[57]), 179'(rfm && !ready));
      chk("ms_allowin", 179'(ms_allowin), 179'(ready && ws_allowin));
      chk("ms_to_es_ex", 179'(ms_to_es_ex), 179'(ex));
      chk("ms_ertn_flush", 179'(ms_ertn_flush), 179'(ertn));
      if (ms_to_ws_valid && ws_allowin) begin
        chk("out_bus", ms_to_ws_bus, exp_bus);
        chk("fwd_final", 179'(ms_forward[38:7]), 179'(fin));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    data_sram_data_ok = 1'b0;
    if (!done) chk("instr_timeout", 179'(0), 179'(1));
    chk("empty_after_leave", 179'(ms_to_es_valid), 179'(0));
  endtask

  initial begin
    logic [178:0] b;
    int op;
    logic exb;
    reset = 1'b1;
    final_ex = 1'b0;
    back_ertn_flush = 1'b0;
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    step();
    step();
    chk("rst_allowin", 179'(ms_allowin), 179'(1));
    chk("rst_to_ws_valid", 179'(ms_to_ws_valid), 179'(0));
    chk("rst_bus", ms_to_ws_bus, '0);
    chk("rst_forward", 179'(ms_forward), 179'(0));
    chk("rst_misc", 179'({ms_ertn_flush, ms_to_es_valid, ms_to_es_ex}), 179'(0));
    reset = 1'b0;
    step();

    // Directed loads, stores and exceptions
    run_instr(OP_LDW,  2'd0, 1'b0, 1'b0, 32'h0000_1000, 32'h89AB_CDEF, 2, 1);
    run_instr(OP_LDB,  2'd3, 1'b0, 1'b0, 32'h0000_1003, 32'h80FF_7F00, 1, 1);
    run_instr(OP_LDBU, 2'd3, 1'b0, 1'b0, 32'h0000_1003, 32'h80FF_7F00, 0, 1);
    run_instr(OP_LDH,  2'd2, 1'b0, 1'b0, 32'h0000_1002, 32'h80FF_7F00, 1, 1);
    run_instr(OP_LDHU, 2'd0, 1'b0, 1'b0, 32'h0000_1000, 32'h1234_ABCD, 0, 2);
    run_instr(OP_LDW,  2'd0, 1'b0, 1'b0, 32'h0000_2000, 32'hCAFE_F00D, 1, 1);
    run_instr(OP_STW,  2'd0, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 2, 1);
    run_instr(OP_ALU,  2'd0, 1'b1, 1'b0, 32'hDEAD_0008, 32'h0, 0, 1);
    run_instr(OP_ALU,  2'd1, 1'b0, 1'b1, 32'h1111_2222, 32'h0, 0, 0);

    // Flush while a load waits: the stale beat must not complete the next load
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(OP_LDW, 2'd0, 1'b0, 1'b0, 32'h4000);
    ws_allowin     = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    final_ex = 1'b1;
    #1;
    chk("flush_no_valid", 179'(ms_to_ws_valid), 179'(0));
    step();
    final_ex = 1'b0;
    b = mk(OP_LDW, 2'd0, 1'b0, 1'b0, 32'h5000);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    #1;
    chk("flush_allowin", 179'(ms_allowin), 179'(1));
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("drop_beat_valid", 179'(ms_to_ws_valid), 179'(0));
    chk("drop_beat_ldblk", 179'(ms_forward[57]), 179'(1));
    step();
    data_sram_rdata = 32'h55AA_55AA;
    #1;
    chk("after_drop_valid", 179'(ms_to_ws_valid), 179'(1));
    chk("after_drop_data", 179'(ms_to_ws_bus[63:32]), 179'(32'h55AA_55AA));
    step();
    data_sram_data_ok = 1'b0;
    #1;
    chk("after_drop_empty", 179'(ms_to_es_valid), 179'(0));

    // Reset in the middle of a load
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(OP_LDW, 2'd0, 1'b0, 1'b0, 32'h6000);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    chk("midload_valid", 179'(ms_to_es_valid), 179'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("midrst_valid", 179'(ms_to_es_valid), 179'(0));
    chk("midrst_allowin", 179'(ms_allowin), 179'(1));
    chk("midrst_forward", 179'(ms_forward), 179'(0));
    step();

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      op  = $urandom_range(0, 8);
      exb = (op >= OP_STB) && ($urandom_range(0, 7) == 0);
      run_instr(op, 2'($urandom), exb, 1'($urandom_range(0, 7) == 0), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage of the LoongArch five-stage core.
- Accepts the execute-to-memory bus and consumes the data-SRAM response (data_ok/rdata) for the request issued in EXE.
- Performs load byte/half selection and sign/zero extension, buffers a response that arrives while WB stalls, and drops responses belonging to flushed instructions.
- Drives the forwarding bus and the exception/ertn indications back to EXE.

Parameters:
- TLBNUM, 16, TLB entries; index field pass-through only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- final_ex  in  1  exception flush from WB
- back_ertn_flush  in  1  ertn flush from WB
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MS can accept
- es_to_ms_valid  in  1  EXE output valid
- es_to_ms_bus  in  179  see field map
- ms_to_ws_valid  out  1  MS output valid
- ms_to_ws_bus  out  179  same layout as input
- data_sram_data_ok  in  1  response strobe
- data_sram_rdata  in  32  response data
- ms_forward  out  58  bypass/hazard bus
- ms_ertn_flush  out  1  ms_valid & ertn
- ms_to_es_valid  out  1  equals ms_valid
- ms_to_es_ex  out  1  ms_valid & ex

Behaviour:
- Input field map:
  - [178:171] TLB pass-through
  - [170] st_w, [169] rdcntid, [168] ertn, [167] esubcode
  - [166:161] ecode, [160] ex
  - [159] csr_re, [158:145] csr_num, [144:113] csr_wvalue, [112:81] csr_wmask, [80] csr_we
  - [79:78] addr[1:0]
  - [77:71] ld_w, ld_b, ld_bu, ld_h, ld_hu, st_b, st_h
  - [70] res_from_mem, [69] gr_we, [68:64] dest, [63:32] result, [31:0] pc
- EXE issues a data request iff the instruction is a load or store with ex=0. Hence need_resp = ms_valid & (res_from_mem | st_b | st_h | st_w) & ~ex.
- Pipeline register:
  - ms_valid resets to 0 and is cleared on final_ex or back_ertn_flush; otherwise it loads es_to_ms_valid when ms_allowin.
  - The bus register is latched on es_to_ms_valid & ms_allowin.
- Handshake:
  - ms_ready_go = ~need_resp | resp_seen.
  - resp_seen = buf_valid | (data_ok & ~drop).
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go.
- Response buffer (rdata_buf, buf_valid):
  - On data_ok & ~drop & need_resp & ~ws_allowin: capture rdata and set buf_valid.
  - Clear buf_valid when the instruction leaves (ms_to_ws_valid & ws_allowin), on flush, or on reset.
- Drop state machine, states IDLE and DROP:
  - IDLE->DROP when a flush occurs while need_resp & ~resp_seen.
  - DROP->IDLE on data_ok; that beat is discarded.
  - While in DROP, a newly entered instruction's need_resp cannot complete.
  - Reset forces IDLE.
- Load data: rd = buf_valid ? rdata_buf : rdata. Byte/half is selected by addr[1:0] (half uses addr[1]).
  - ld_b/ld_h sign-extend; ld_bu/ld_hu zero-extend; ld_w passes through.
  - final = res_from_mem ? loaddata : result.
- Output bus:
  - Input bus with [63:32] = final, [70] forced 0, [160] = ex & ms_valid.
  - Combinational in the same cycle as ready_go.
- ms_forward fields:
  - [57] ld_block = ms_valid & res_from_mem & ~ms_ready_go
  - [56] csr_re, [55:42] csr_num, [41] csr_we
  - [40] ertn, [39] ex
  - [38:7] final, [6:2] dest, [1] gr_we, [0] ms_valid
- Reset values: all outputs 0 except ms_allowin = 1.
- Simultaneous events:
  - Flush takes priority over load/capture.
  - A new instruction entering in the same cycle as data_ok of the departing one: the data belongs to the departing instruction.

Test Plan:
- ld.w, addr 0x1000, data_ok 2 cycles after entry, rdata 0x89ABCDEF, ws_allowin=1 -> ms_to_ws_valid rises in the data_ok cycle; bus[63:32] = 0x89ABCDEF; ld_block = 1 for the preceding cycle.
- ld.b with addr[1:0]=3, rdata 0x80FF7F00 -> final 0xFFFFFF80. Same with ld.bu -> 0x00000080. ld.h with addr[1:0]=2 -> 0xFFFF80FF.
- ld.hu, ws_allowin=0 on data_ok with rdata 0x1234ABCD, addr 0; ws_allowin=1 three cycles later -> buf_valid held, output 0x0000ABCD, buf cleared after transfer.
- final_ex while a load awaits data_ok, next instruction is ld.w entering the cycle after -> the first data_ok is dropped, ms_to_ws_valid stays 0, and the second data_ok (0x55AA55AA) completes the new load.
- st.w with ex=0 -> ready only on data_ok. Instruction with ex=1, ecode 0x8 (ADEF) -> ready immediately, ms_to_es_ex = 1, bus[160] = 1, no data_ok awaited.
- ertn instruction valid -> ms_ertn_flush = 1 for its residency. reset asserted mid-load -> ms_valid = 0, ms_allowin = 1 next cycle.
